uart_tx_buf: RTL and testbench
==============================

Name: uart_tx_buf

Overview:
- Downstream consumer of the data_send request stage.
- Each single-cycle req reads the next byte from the synchronous frame-buffer RAM and serialises it 8N1, LSB first, on the UART line.
- Drives txBusy back to data_send so it can pace its 512 requests.
- Owns the buffer read-address counter; the writer side clears it at frame start.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- DEPTH, 512, buffer depth in bytes; must be a power of two.
- AW, 9, address width, log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  single-cycle request to send the next byte.
- addr_clr  in  1  synchronous pulse; sets the read address to 0.
- rd_addr  out  AW  buffer read address; registered, always driven.
- rd_data  in  8  buffer read data, valid one clock after rd_addr changes.
- tx  out  1  UART line; idles high.
- txBusy  out  1  high while a byte is being fetched or sent.

Behaviour:
- Reset values:
  - tx=1, txBusy=0, rd_addr=0, state=IDLE.
  - Shift register, bit counter and baud counter all 0.
  - Reset asserted mid-frame aborts immediately: tx returns to 1, no partial recovery.
- txBusy = busy_reg OR (req AND state==IDLE), combinational. data_send samples txBusy in the same cycle its registered req is high, so busy must be visible in that cycle.
- States:
  - IDLE: on req, go to FETCH.
  - FETCH: one cycle, waiting on RAM latency.
  - LOAD: capture rd_data into the shift register, rd_addr <= rd_addr+1, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing, with req sampled high at cycle T:
  - FETCH at T+1, LOAD at T+2.
  - tx falls at T+3.
  - Frame lasts exactly 10*CLKS_PER_BIT cycles.
  - busy_reg is high from T+1 through the last STOP cycle; txBusy is low on the first cycle back in IDLE.
- Back-to-back: a req arriving in the first IDLE cycle starts the next frame with no extra gap. Line idle time between frames is therefore 3 cycles minimum (IDLE, FETCH, LOAD).
- req while busy_reg=1 is ignored; no queuing, no error flag.
- The baud counter is 16 bits and restarts at 0 on every state entry. A bit ends when count == CLKS_PER_BIT-1.
- Address wrap: DEPTH-1 increments to 0.
- addr_clr:
  - Sets rd_addr to 0 in any state.
  - Takes priority over the LOAD increment in the same cycle.
  - Never disturbs a frame in progress.
- tx is driven from a flop (glitch-free). rd_addr is a flop.

Decomposition:
- Shared package (uart_pkg):
  - State encoding localparams: IDLE=0, FETCH=1, LOAD=2, START=3, DATA=4, STOP=5, in a 3-bit state register with safe encoding.
  - Default CLKS_PER_BIT and the UART frame length constant (10 bits).
- One sub-module, uart_baud_cnt:
  - Inputs: clk, rst, clear, and CLKS_PER_BIT as a parameter.
  - Output: bit_done pulse.
  - Reused later by the RX stage.

Test Plan (CLKS_PER_BIT=4, DEPTH=8, RAM model with 1-cycle latency, RAM[i]=8'hA0+i):
1. Reset, then req pulse at T -> txBusy=1 at T. tx=0 during T+3..T+6. Data bits read 0,0,0,0,0,1,0,1 (0xA0, LSB first). tx=1 during stop. txBusy=0 at T+43. rd_addr=1.
2. req pulse held for one cycle, then req pulsed again at T+20 (mid-frame) -> ignored: exactly one frame, rd_addr=1.
3. Drive the data_send handshake model for 8 bytes -> bytes A0..A7 received in order. Inter-frame idle is 3 cycles. rd_addr wraps to 0 after A7.
4. addr_clr at the LOAD cycle of byte 3 -> byte 3 (A3) is sent intact. rd_addr=0 afterward, not 4. Next req sends A0.
5. rst asserted at T+15 mid-frame -> tx=1, txBusy=0 and rd_addr=0 within the same cycle (asynchronous). A req after release sends A0 cleanly.
6. Set CLKS_PER_BIT=2 -> frame is 20 cycles. Each bit is held exactly 2 cycles, checked by a sampler at bit centres.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART stages.
//   CLKS_PER_BIT_DEF : default baud divider (50 MHz / 115200)
//   FRAME_BITS       : 8N1 frame length in bit periods (start + 8 data + stop)
//   DATA_BITS        : payload bits per frame
//   tx_state_e       : transmitter FSM encoding
//   is_pow2()        : parameter sanity helper
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned FRAME_BITS       = 10;
  localparam int unsigned DATA_BITS        = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StStart = 3'd3,
    StData  = 3'd4,
    StStop  = 3'd5
  } tx_state_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter. Counts clock cycles and pulses o_bit_done on the last
// cycle of each bit period; restarts at 0 after every bit and while i_clear
// is held.
// Ports:
//   i_clk      : system clock
//   i_rst      : asynchronous active-high reset
//   i_clear    : hold the count at 0 (used outside timed states)
//   o_bit_done : high on the final cycle of a bit period
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_bit_done
);

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

  logic [15:0] r_cnt;

  assign o_bit_done = (r_cnt == LastCnt) && !i_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_bit_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// UART transmitter fed from a synchronous frame-buffer RAM. Each single-cycle
// request fetches the byte at the current read address and sends it 8N1,
// LSB first. The read address advances once per byte and wraps at DEPTH.
// Ports:
//   i_clk      : system clock
//   i_rst      : asynchronous active-high reset
//   i_req      : single-cycle request to send the next byte
//   i_addr_clr : synchronous pulse, sets the read address to 0
//   o_rd_addr  : buffer read address (registered)
//   i_rd_data  : buffer read data, valid one clock after o_rd_addr changes
//   o_tx       : UART line, idles high (registered)
//   o_tx_busy  : high while a byte is being fetched or sent
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned AW           = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic          i_addr_clr,
  output logic [AW-1:0] o_rd_addr,
  input  logic [7:0]    i_rd_data,
  output logic          o_tx,
  output logic          o_tx_busy
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_buf: CLKS_PER_BIT out of range");
  end
  if (!is_pow2(DEPTH) || (AW != $clog2(DEPTH))) begin : g_bad_depth
    $error("uart_tx_buf: DEPTH must be a power of two and AW = log2(DEPTH)");
  end

  tx_state_e     r_state, w_state_d;
  logic [7:0]    r_shift, w_shift_d;
  logic [2:0]    r_bit_cnt, w_bit_cnt_d;
  logic [AW-1:0] r_rd_addr, w_rd_addr_d;
  logic          r_tx, w_tx_d;
  logic          r_busy, w_busy_d;
  logic          w_bit_done;
  logic          w_baud_clr;

  // Counter only runs in the bit-timed states, so it is at 0 on entry to each.
  assign w_baud_clr = !((r_state == StStart) || (r_state == StData) || (r_state == StStop));

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_baud_clr),
    .o_bit_done(w_bit_done)
  );

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_bit_cnt_d = r_bit_cnt;
    w_tx_d      = 1'b1;

    case (r_state)
      StIdle: begin
        if (i_req) begin
          w_state_d = StFetch;
        end
      end
      // RAM read latency: rd_data for the current address lands next cycle.
      StFetch: begin
        w_state_d = StLoad;
      end
      StLoad: begin
        w_shift_d   = i_rd_data;
        w_bit_cnt_d = '0;
        w_state_d   = StStart;
      end
      StStart: begin
        if (w_bit_done) begin
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_bit_done) begin
          w_shift_d = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
            w_bit_cnt_d = '0;
            w_state_d   = StStop;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 3'd1;
          end
        end
      end
      StStop: begin
        if (w_bit_done) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Line value is computed for the state being entered so o_tx is a flop.
    case (w_state_d)
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_shift_d[0];
      default: w_tx_d = 1'b1;
    endcase
  end

  // Clear wins over the post-load increment; the byte already latched is unaffected.
  always_comb begin
    w_rd_addr_d = r_rd_addr;
    if (i_addr_clr) begin
      w_rd_addr_d = '0;
    end else if (r_state == StLoad) begin
      w_rd_addr_d = r_rd_addr + AW'(1);
    end
  end

  assign w_busy_d = (w_state_d != StIdle);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_rd_addr <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_rd_addr <= w_rd_addr_d;
      r_tx      <= w_tx_d;
      r_busy    <= w_busy_d;
    end
  end

  assign o_rd_addr = r_rd_addr;
  assign o_tx      = r_tx;
  // Requester samples busy in the same cycle its req is high.
  assign o_tx_busy = r_busy || (i_req && (r_state == StIdle));

endmodule

// File: tb/tb_uart_tx_buf.sv
module tb_uart_tx_buf;

  localparam int unsigned Depth = 8;
  localparam int unsigned Aw    = 3;

  logic clk = 1'b0;
  logic rst, req, addr_clr, sel_b;
  logic req_a, req_b;
  logic [Aw-1:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic tx_a, tx_b, busy_a, busy_b;
  logic tx_obs, busy_obs;
  logic [Aw-1:0] addr_obs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign req_a    = req & ~sel_b;
  assign req_b    = req & sel_b;
  assign tx_obs   = sel_b ? tx_b : tx_a;
  assign busy_obs = sel_b ? busy_b : busy_a;
  assign addr_obs = sel_b ? rd_addr_b : rd_addr_a;

  // Frame-buffer RAM models, 1-cycle latency, RAM[i] = A0 + i.
  always @(posedge clk) rd_data_a <= 8'hA0 + 8'(rd_addr_a);
  always @(posedge clk) rd_data_b <= 8'hA0 + 8'(rd_addr_b);

  uart_tx_buf #(.CLKS_PER_BIT(4), .DEPTH(Depth), .AW(Aw)) u_dut_a (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req_a),
    .i_addr_clr(addr_clr),
    .o_rd_addr (rd_addr_a),
    .i_rd_data (rd_data_a),
    .o_tx      (tx_a),
    .o_tx_busy (busy_a)
  );

  uart_tx_buf #(.CLKS_PER_BIT(2), .DEPTH(Depth), .AW(Aw)) u_dut_b (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req_b),
    .i_addr_clr(addr_clr),
    .o_rd_addr (rd_addr_b),
    .i_rd_data (rd_data_b),
    .o_tx      (tx_b),
    .o_tx_busy (busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected line level k cycles after the cycle in which req was accepted.
  function automatic logic exp_tx(input int k, input int c, input logic [7:0] b);
    int j;
    if (k < 3) return 1'b1;
    j = (k - 3) / c;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    req = 1'b0;
    addr_clr = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_tx", tx_obs, 1);
    check_eq("rst_busy", busy_obs, 0);
    check_eq("rst_addr", addr_obs, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic start_req(input string tag);
    @(posedge clk);
    #1 req = 1'b1;
    @(negedge clk);
    check_eq(tag, busy_obs, 1);
  endtask

  // Checks line and busy every cycle of a frame. inj_kind 1: extra req at
  // cycle inj_k; 2: addr_clr at cycle inj_k. chain raises req in the first
  // idle cycle so the next frame follows with no extra gap.
  task automatic frame(input int c, input logic [7:0] b, input int inj_k, input int inj_kind,
                       input bit chain, input string tag);
    int errs;
    int last;
    errs = 0;
    last = 3 + 10 * c;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1 req = 1'b0;
      addr_clr = 1'b0;
      if (k == inj_k && inj_kind == 1) req = 1'b1;
      if (k == inj_k && inj_kind == 2) addr_clr = 1'b1;
      if (k == last && chain) req = 1'b1;
      @(negedge clk);
      if (tx_obs !== exp_tx(k, c, b)) errs++;
      if (busy_obs !== ((k < last) || chain)) errs++;
    end
    check_eq(tag, errs, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    rst = 1'b0;
    req = 1'b0;
    addr_clr = 1'b0;
    sel_b = 1'b0;

    // 1: single frame of A0.
    do_reset();
    start_req("t1_busy_at_t");
    frame(4, 8'hA0, 0, 0, 1'b0, "t1_frame_a0");
    check_eq("t1_addr", addr_obs, 1);

    // 2: req mid-frame is ignored.
    do_reset();
    start_req("t2_busy_at_t");
    frame(4, 8'hA0, 20, 1, 1'b0, "t2_frame_a0");
    check_eq("t2_addr", addr_obs, 1);
    quiet = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (tx_obs !== 1'b1 || busy_obs !== 1'b0) quiet++;
    end
    check_eq("t2_one_frame", quiet, 0);

    // 3: back-to-back A0..A7, address wraps.
    do_reset();
    start_req("t3_busy_at_t");
    for (int i = 0; i < 8; i++) begin
      frame(4, 8'hA0 + 8'(i), 0, 0, (i < 7), $sformatf("t3_frame_%0d", i));
    end
    check_eq("t3_addr_wrap", addr_obs, 0);

    // 4: addr_clr in LOAD cycle of the fourth byte.
    start_req("t4_busy_at_t");
    frame(4, 8'hA0, 0, 0, 1'b1, "t4_frame_0");
    frame(4, 8'hA1, 0, 0, 1'b1, "t4_frame_1");
    frame(4, 8'hA2, 0, 0, 1'b1, "t4_frame_2");
    frame(4, 8'hA3, 2, 2, 1'b0, "t4_frame_3_clr");
    check_eq("t4_addr_clr", addr_obs, 0);
    start_req("t4_busy_next");
    frame(4, 8'hA0, 0, 0, 1'b0, "t4_frame_after");

    // 5: asynchronous reset mid-frame.
    do_reset();
    start_req("t5_busy_at_t");
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1 req = 1'b0;
    end
    @(negedge clk);
    check_eq("t5_mid_tx", tx_obs, 0);
    check_eq("t5_mid_addr", addr_obs, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("t5_async_tx", tx_obs, 1);
    check_eq("t5_async_busy", busy_obs, 0);
    check_eq("t5_async_addr", addr_obs, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    start_req("t5_busy_after");
    frame(4, 8'hA0, 0, 0, 1'b0, "t5_frame_after");

    // 6: CLKS_PER_BIT = 2 instance, 20-cycle frame.
    sel_b = 1'b1;
    do_reset();
    start_req("t6_busy_at_t");
    frame(2, 8'hA0, 0, 0, 1'b0, "t6_frame_cpb2");
    check_eq("t6_addr", addr_obs, 1);
    start_req("t6_busy_next");
    frame(2, 8'hA1, 0, 0, 1'b0, "t6_frame_a1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
